// File: rtl/ctrl_pkg.sv
// Shared definitions for the trigger/capture sequencer.
// Holds the FSM state encoding, capture-mode constants and the default
// frame length. No ports.
package ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_NORMAL = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;

  localparam int unsigned CAP_LEN_DEFAULT = 43;

  // Modes that re-enter ARMED after a completed frame; code 3 acts as single.
  function automatic logic is_rearm_mode(input logic [1:0] m);
    return (m == MODE_NORMAL) || (m == MODE_AUTO);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Programmable sample-rate divider.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : preload so the first enabled cycle produces a tick
//   en       : count enable
//   div      : tick period is div+1 enabled clocks
//   tick     : one-clock tick output (combinational from the count)
module sample_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] div,
  output logic        tick
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = div;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/trig_capture_ctrl.sv
// Trigger/capture sequencer for the 8-bit logic-capture path.
// Arms on request, waits for a masked pattern (level or rising-edge) trigger
// or an auto-mode timeout, then writes CAP_LEN samples into the capture RAM
// at a programmable rate.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   arm, abort         : one-clock control pulses (abort has priority)
//   mode, sample_div   : capture mode and sample divider, latched on arm
//   q, q_set, q_mask   : probe data, trigger pattern, participating bits
//   edge_en            : 1 = rising edge of match, 0 = level (latched on arm)
//   ram_wren/waddr/wdata : capture RAM write port
//   armed, busy        : state indicators
//   frame_valid, frame_cnt, timeout_flag : status for the display path
module trig_capture_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CAP_LEN = CAP_LEN_DEFAULT,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned AUTO_TO = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [31:0]       sample_div,
  input  logic [7:0]        q,
  input  logic [7:0]        q_set,
  input  logic [7:0]        q_mask,
  input  logic              edge_en,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [7:0]        ram_wdata,
  output logic              armed,
  output logic              busy,
  output logic              frame_valid,
  output logic [7:0]        frame_cnt,
  output logic              timeout_flag
);

  state_e            state_q, state_d;
  logic [7:0]        q_r_q, q_r_d;
  logic              match_prev_q, match_prev_d;
  logic [1:0]        mode_q, mode_d;
  logic [31:0]       div_q, div_d;
  logic              edge_en_q, edge_en_d;
  logic [31:0]       to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              fv_q, fv_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic              tflag_q, tflag_d;

  logic match, trig, to_hit, tick;

  sample_tick_gen u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (state_q != S_CAPTURE),
    .en   (state_q == S_CAPTURE),
    .div  (div_q),
    .tick (tick)
  );

  always_comb begin
    q_r_d        = q;
    match        = (((q_r_q ^ q_set) & q_mask) == '0);
    match_prev_d = match;
    trig         = edge_en_q ? (match & ~match_prev_q) : match;
    to_hit       = (mode_q == MODE_AUTO) && (to_cnt_q == 32'(AUTO_TO - 1));

    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    edge_en_d = edge_en_q;
    to_cnt_d  = to_cnt_q;
    idx_d     = idx_q;
    wren_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    fv_d      = fv_q;
    fcnt_d    = fcnt_q;
    tflag_d   = tflag_q;

    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d   = S_ARMED;
          mode_d    = mode;
          div_d     = sample_div;
          edge_en_d = edge_en;
          to_cnt_d  = '0;
        end
      end
      S_ARMED: begin
        if (trig || to_hit) begin
          state_d = S_CAPTURE;
          tflag_d = ~trig;      // a real trigger in the timeout cycle wins
          fv_d    = 1'b0;
          idx_d   = '0;
        end else if (mode_q == MODE_AUTO) begin
          to_cnt_d = to_cnt_q + 32'd1;
        end
      end
      S_CAPTURE: begin
        // The final write is still registered when the FSM moves to DONE,
        // so it appears on the RAM port during the DONE cycle.
        if (tick) begin
          wren_d  = 1'b1;
          waddr_d = idx_q;
          wdata_d = q_r_q;
          idx_d   = idx_q + ADDR_W'(1);
          if (idx_q == ADDR_W'(CAP_LEN - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        fv_d   = 1'b1;
        fcnt_d = fcnt_q + 8'd1;
        if (is_rearm_mode(mode_q)) begin
          state_d  = S_ARMED;
          to_cnt_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort freezes all status and cancels the write scheduled this cycle.
    if (abort) begin
      state_d   = S_IDLE;
      mode_d    = mode_q;
      div_d     = div_q;
      edge_en_d = edge_en_q;
      to_cnt_d  = to_cnt_q;
      idx_d     = idx_q;
      wren_d    = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      fv_d      = fv_q;
      fcnt_d    = fcnt_q;
      tflag_d   = tflag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      q_r_q        <= '0;
      match_prev_q <= 1'b0;
      mode_q       <= MODE_SINGLE;
      div_q        <= '0;
      edge_en_q    <= 1'b0;
      to_cnt_q     <= '0;
      idx_q        <= '0;
      wren_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      fv_q         <= 1'b0;
      fcnt_q       <= '0;
      tflag_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_r_q        <= q_r_d;
      match_prev_q <= match_prev_d;
      mode_q       <= mode_d;
      div_q        <= div_d;
      edge_en_q    <= edge_en_d;
      to_cnt_q     <= to_cnt_d;
      idx_q        <= idx_d;
      wren_q       <= wren_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      fv_q         <= fv_d;
      fcnt_q       <= fcnt_d;
      tflag_q      <= tflag_d;
    end
  end

  assign ram_wren     = wren_q;
  assign ram_waddr    = waddr_q;
  assign ram_wdata    = wdata_q;
  assign armed        = (state_q == S_ARMED);
  assign busy         = (state_q != S_IDLE);
  assign frame_valid  = fv_q;
  assign frame_cnt    = fcnt_q;
  assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Directed bench for trig_capture_ctrl (CAP_LEN=43, AUTO_TO=100).
module tb_trig_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst, arm, abort, edge_en;
  logic [1:0]  mode;
  logic [31:0] sample_div;
  logic [7:0]  q, q_set, q_mask;
  logic        ram_wren;
  logic [5:0]  ram_waddr;
  logic [7:0]  ram_wdata;
  logic        armed, busy, frame_valid, timeout_flag;
  logic [7:0]  frame_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned exp_cnt  = 0;

  always #5 clk = ~clk;

  trig_capture_ctrl #(.CAP_LEN(43), .ADDR_W(6), .AUTO_TO(100)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .mode(mode),
    .sample_div(sample_div), .q(q), .q_set(q_set), .q_mask(q_mask),
    .edge_en(edge_en), .ram_wren(ram_wren), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .armed(armed), .busy(busy),
    .frame_valid(frame_valid), .frame_cnt(frame_cnt),
    .timeout_flag(timeout_flag)
  );

  typedef struct {
    logic [7:0] qv;
    logic [7:0] setv;
    logic [7:0] maskv;
    logic       exp_armed;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wren"},  32'(ram_wren), 32'd0);
    chk({tag, "_waddr"}, 32'(ram_waddr), 32'd0);
    chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
    chk({tag, "_armed"}, 32'(armed), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_fv"},    32'(frame_valid), 32'd0);
    chk({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
    chk({tag, "_tflag"}, 32'(timeout_flag), 32'd0);
  endtask

  // Caller is in ARMED with q_set=5A, mask=FF and q not yet triggering.
  // q=5A is driven now; q then changes every cycle so wdata shows which
  // registered sample each write carries.
  task automatic run_capture(input int unsigned period, input logic exp_rearm);
    logic [7:0]  hist [0:255];
    int unsigned nwr;
    int unsigned limit;
    nwr     = 0;
    limit   = 3 + 43 * period + 4;
    hist[0] = 8'h5A;
    q       = hist[0];
    for (int unsigned i = 1; i < limit && nwr < 43; i++) begin
      step();
      if (ram_wren) begin
        chk("wr_time", i, 3 + nwr * period);
        chk("wr_addr", 32'(ram_waddr), nwr);
        chk("wr_data", 32'(ram_wdata), (i >= 2) ? 32'(hist[i-2]) : 32'hFFFF);
        if (nwr == 0) chk("wr_fv_clear", 32'(frame_valid), 32'd0);
        nwr++;
      end
      hist[i] = 8'(i * 29 + 3);
      q       = hist[i];
    end
    chk("wr_count", nwr, 32'd43);
    step();
    exp_cnt++;
    chk("done_fv",    32'(frame_valid), 32'd1);
    chk("done_fcnt",  32'(frame_cnt), exp_cnt);
    chk("done_busy",  32'(busy), 32'(exp_rearm));
    chk("done_armed", 32'(armed), 32'(exp_rearm));
  endtask

  initial begin
    vec_t        vecs [7];
    int unsigned n, nw, k;

    vecs[0] = '{8'h5A, 8'h5A, 8'hFF, 1'b0};
    vecs[1] = '{8'h5B, 8'h5A, 8'hFF, 1'b1};
    vecs[2] = '{8'h5B, 8'h5A, 8'hFE, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'hA5, 8'h5A, 8'h0F, 1'b1};
    vecs[5] = '{8'hA5, 8'h25, 8'h7F, 1'b0};
    vecs[6] = '{8'h80, 8'h00, 8'h80, 1'b1};

    rst = 1'b1; arm = 1'b0; abort = 1'b0; edge_en = 1'b0; mode = 2'd0;
    sample_div = 32'd0; q = 8'h00; q_set = 8'h5A; q_mask = 8'hFF;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Trigger compare table: armed after one ARMED cycle means no trigger
    foreach (vecs[v]) begin
      do_reset();
      q = vecs[v].qv; q_set = vecs[v].setv; q_mask = vecs[v].maskv;
      mode = 2'd0; edge_en = 1'b0; sample_div = 32'd0;
      step(); step();
      pulse_arm();
      step();
      chk("vec_armed", 32'(armed), 32'(vecs[v].exp_armed));
      chk("vec_busy",  32'(busy), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("vec_abort_busy", 32'(busy), 32'd0);
      chk("vec_abort_wren", 32'(ram_wren), 32'd0);
    end

    // Single mode, level trigger, every clock
    do_reset();
    q_set = 8'h5A; q_mask = 8'hFF; q = 8'h00; mode = 2'd0; sample_div = 32'd0;
    pulse_arm();
    for (int i = 0; i < 5; i++) step();
    chk("single_wait_armed", 32'(armed), 32'd1);
    run_capture(1, 1'b0);

    // Sample rate div=3; changes to mode/sample_div after arm are ignored
    q = 8'h00; sample_div = 32'd3; mode = 2'd0;
    pulse_arm();
    sample_div = 32'd0; mode = 2'd1;
    run_capture(4, 1'b0);

    // Edge mode: steady match must not trigger
    q = 8'h5A; edge_en = 1'b1; mode = 2'd0; sample_div = 32'd0;
    step(); step();
    pulse_arm();
    edge_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("edge_hold_armed", 32'(armed), 32'd1);
    q = 8'h00;
    step();
    chk("edge_low_armed", 32'(armed), 32'd1);
    run_capture(1, 1'b0);

    // Normal mode re-arms; abort from ARMED keeps frame_valid
    q = 8'h00; mode = 2'd1;
    pulse_arm();
    run_capture(1, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_armed_busy", 32'(busy), 32'd0);
    chk("abort_armed_fv",   32'(frame_valid), 32'd1);

    // arm and abort together stay IDLE
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_busy", 32'(busy), 32'd0);
    step();
    chk("arm_abort_busy2", 32'(busy), 32'd0);

    // Abort right after the write to address 10
    q = 8'h00; mode = 2'd1;
    pulse_arm();
    q = 8'h5A;
    n = 0;
    while (!(ram_wren && ram_waddr == 6'd10) && n < 60) begin
      step();
      n++;
    end
    chk("abort_found_addr10", 32'(ram_wren && ram_waddr == 6'd10), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_cap_wren", 32'(ram_wren), 32'd0);
    chk("abort_cap_busy", 32'(busy), 32'd0);
    chk("abort_cap_fv",   32'(frame_valid), 32'd0);
    chk("abort_cap_fcnt", 32'(frame_cnt), exp_cnt);
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ram_wren) nw++;
    end
    chk("abort_no_writes", nw, 32'd0);

    // Auto mode, never matching: timeout-forced frames back to back
    q = 8'h00; mode = 2'd2;
    pulse_arm();
    chk("auto_armed", 32'(armed), 32'd1);
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (armed && n < 200) begin
        step();
        n++;
      end
      chk("auto_delay", n, 32'd100);
      chk("auto_tflag", 32'(timeout_flag), 32'd1);
      nw = 0; k = 0;
      while (32'(frame_cnt) == exp_cnt && k < 100) begin
        step();
        if (ram_wren) nw++;
        k++;
      end
      exp_cnt++;
      chk("auto_writes", nw, 32'd43);
      chk("auto_fcnt",   32'(frame_cnt), exp_cnt);
      chk("auto_rearm",  32'(armed), 32'd1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Trigger in the same cycle as the timeout: trigger wins
    q = 8'h00; mode = 2'd2;
    pulse_arm();
    for (int i = 0; i < 98; i++) step();
    chk("coinc_still_armed", 32'(armed), 32'd1);
    q = 8'h5A;
    step();
    chk("coinc_armed_99", 32'(armed), 32'd1);
    step();
    chk("coinc_armed", 32'(armed), 32'd0);
    chk("coinc_busy",  32'(busy), 32'd1);
    chk("coinc_tflag", 32'(timeout_flag), 32'd0);

    // Reset in the middle of a capture
    for (int i = 0; i < 5; i++) step();
    chk("midcap_wren", 32'(ram_wren), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("midcap_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
